// File: rtl/ub_stream_sched_pkg.sv
// Shared types and constants for the stream scheduler and its iterators.
package ub_ctrl_pkg;

    localparam int unsigned CTRL_W   = 16;
    localparam int unsigned NUM_DIMS = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_t;

    typedef logic [NUM_DIMS-1:0][CTRL_W-1:0] ctrl_vars_t;

endpackage

// File: rtl/ub_stream_sched_if.sv
// Control and buffer-port bundle of the stream scheduler.
interface ub_stream_sched_if;
    import ub_ctrl_pkg::*;

    logic       flush;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic       wr_wen;
    ctrl_vars_t wr_ctrl_vars;
    logic       rd_ren;
    ctrl_vars_t rd_ctrl_vars;

    // master: the scheduler itself; slave: the controller/buffer side.
    modport master (
        input  flush, start, stall,
        output busy, done, wr_wen, wr_ctrl_vars, rd_ren, rd_ctrl_vars
    );

    modport slave (
        output flush, start, stall,
        input  busy, done, wr_wen, wr_ctrl_vars, rd_ren, rd_ctrl_vars
    );

endinterface

// File: rtl/ub_stream_sched_iter.sv
// One loop-nest iterator: [1] fastest, then [2], then [0], each wrapping with carry.
module ub_affine_iter
    import ub_ctrl_pkg::*;
#(
    parameter int unsigned EXT0 = 1,
    parameter int unsigned EXT1 = 64,
    parameter int unsigned EXT2 = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output ctrl_vars_t ctrl_vars,
    output logic       last
);

    localparam logic [CTRL_W-1:0] MAX0 = CTRL_W'(EXT0 - 1);
    localparam logic [CTRL_W-1:0] MAX1 = CTRL_W'(EXT1 - 1);
    localparam logic [CTRL_W-1:0] MAX2 = CTRL_W'(EXT2 - 1);

    logic wrap0;
    logic wrap1;
    logic wrap2;

    assign wrap0 = (ctrl_vars[0] == MAX0);
    assign wrap1 = (ctrl_vars[1] == MAX1);
    assign wrap2 = (ctrl_vars[2] == MAX2);
    assign last  = wrap0 & wrap1 & wrap2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_vars <= '0;
        end else if (clr) begin
            ctrl_vars <= '0;
        end else if (en) begin
            ctrl_vars[1] <= wrap1 ? '0 : ctrl_vars[1] + CTRL_W'(1);
            if (wrap1) begin
                ctrl_vars[2] <= wrap2 ? '0 : ctrl_vars[2] + CTRL_W'(1);
                if (wrap2) begin
                    ctrl_vars[0] <= wrap0 ? '0 : ctrl_vars[0] + CTRL_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ub_stream_sched.sv
// Write/read stream scheduler: one pass over a 3-deep loop nest, reads trailing writes by RD_DELAY.
module ub_stream_sched
    import ub_ctrl_pkg::*;
#(
    parameter int unsigned EXT0     = 1,
    parameter int unsigned EXT1     = 64,
    parameter int unsigned EXT2     = 64,
    parameter int unsigned RD_DELAY = 1
) (
    input logic              clk,
    input logic              rst,
    ub_stream_sched_if.master bus
);

    localparam int unsigned N     = EXT0 * EXT1 * EXT2;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
    localparam logic [CNT_W-1:0] DLY_C = CNT_W'(RD_DELAY);

    if (RD_DELAY < 1 || RD_DELAY > N) begin : g_bad_rd_delay
        $error("ub_stream_sched: RD_DELAY must lie in 1..EXT0*EXT1*EXT2");
    end

    sched_state_t     state;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] gap;
    logic             wr_en;
    logic             rd_en;
    logic             wr_last;
    logic             rd_last;
    ctrl_vars_t       wr_vars;
    ctrl_vars_t       rd_vars;

    always_comb begin
        gap   = wr_cnt - rd_cnt;
        wr_en = (state == ST_RUN) & ~bus.stall & (wr_cnt < N_C);
        rd_en = ((state == ST_RUN) | (state == ST_DRAIN)) & ~bus.stall & (rd_cnt < N_C)
              & ((gap >= DLY_C) | (wr_cnt == N_C));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            done_q <= 1'b0;
            if (wr_en) wr_cnt <= wr_cnt + CNT_W'(1);
            if (rd_en) rd_cnt <= rd_cnt + CNT_W'(1);
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b1;
                    end
                end
                // The last point of an iterator coincides with its count reaching N-1.
                ST_RUN: begin
                    if (wr_en && wr_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (rd_en && rd_last) begin
                        state  <= ST_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                end
            endcase
        end
    end

    ub_affine_iter #(.EXT0(EXT0), .EXT1(EXT1), .EXT2(EXT2)) u_wr_iter (
        .clk       (clk),
        .rst       (rst),
        .en        (wr_en),
        .clr       (bus.flush),
        .ctrl_vars (wr_vars),
        .last      (wr_last)
    );

    ub_affine_iter #(.EXT0(EXT0), .EXT1(EXT1), .EXT2(EXT2)) u_rd_iter (
        .clk       (clk),
        .rst       (rst),
        .en        (rd_en),
        .clr       (bus.flush),
        .ctrl_vars (rd_vars),
        .last      (rd_last)
    );

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.wr_wen       = wr_en;
    assign bus.rd_ren       = rd_en;
    assign bus.wr_ctrl_vars = wr_vars;
    assign bus.rd_ctrl_vars = rd_vars;

endmodule

// File: tb/tb_ub_stream_sched.sv
// Directed bench for ub_stream_sched: default, small-nest and long-delay instances.
module tb_ub_stream_sched;
    import ub_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ub_stream_sched_if ia ();
    ub_stream_sched_if ib ();
    ub_stream_sched_if ic ();

    ub_stream_sched #(.EXT0(1), .EXT1(64), .EXT2(64), .RD_DELAY(1)) u_a (
        .clk (clk), .rst (rst), .bus (ia)
    );
    ub_stream_sched #(.EXT0(1), .EXT1(4), .EXT2(2), .RD_DELAY(1)) u_b (
        .clk (clk), .rst (rst), .bus (ib)
    );
    ub_stream_sched #(.EXT0(1), .EXT1(8), .EXT2(8), .RD_DELAY(64)) u_c (
        .clk (clk), .rst (rst), .bus (ic)
    );

    localparam int E0 [3] = '{1, 1, 1};
    localparam int E1 [3] = '{64, 4, 8};
    localparam int E2 [3] = '{64, 2, 8};
    localparam int RD [3] = '{1, 1, 64};

    typedef struct packed {
        logic       busy, done, stall, wen, ren;
        ctrl_vars_t wv, rv;
    } samp_t;

    typedef struct packed {
        int k;
        int busy_first, busy_last, busy_n;
        int wen_first, wen_last, wen_n;
        int ren_first, ren_last, ren_n;
        int done_k, done_n, drain_ren;
        int ord_err, gate_err, held_err;
        logic       prev_stall;
        ctrl_vars_t prev_wv, prev_rv, wv_first, wv_last;
    } stat_t;

    stat_t st [3];
    int    ep [3] = '{0, 0, 0};
    int    seen [3] = '{0, 0, 0};

    // Expected iteration point of the j-th issue: [1] fastest, [2] next, [0] outermost.
    function automatic ctrl_vars_t pt(int j, int e1, int e2);
        ctrl_vars_t v;
        v[1] = 16'(j % e1);
        v[2] = 16'((j / e1) % e2);
        v[0] = 16'(j / (e1 * e2));
        return v;
    endfunction

    function automatic stat_t upd(stat_t s0, samp_t p, int e0, int e1, int e2, int rdd);
        stat_t s = s0;
        int    n = e0 * e1 * e2;
        logic  exp_w, exp_r;
        s.k++;
        exp_w = p.busy && !p.stall && (s.wen_n < n);
        exp_r = p.busy && !p.stall && (s.ren_n < n) &&
                ((s.wen_n - s.ren_n >= rdd) || (s.wen_n == n));
        if (p.wen !== exp_w || p.ren !== exp_r) s.gate_err++;
        if (p.busy) begin
            if (s.busy_n == 0) s.busy_first = s.k;
            s.busy_last = s.k;
            s.busy_n++;
        end
        if (p.wen) begin
            if (s.wen_n == 0) begin
                s.wen_first = s.k;
                s.wv_first  = p.wv;
            end
            s.wen_last = s.k;
            s.wv_last  = p.wv;
            if (p.wv !== pt(s.wen_n, e1, e2)) s.ord_err++;
            s.wen_n++;
        end
        if (p.ren) begin
            if (s.ren_n == 0) s.ren_first = s.k;
            s.ren_last = s.k;
            if (p.rv !== pt(s.ren_n, e1, e2)) s.ord_err++;
            s.ren_n++;
            if (!p.wen && s.wen_n == n) s.drain_ren++;
        end
        if (p.done) begin
            s.done_k = s.k;
            s.done_n++;
        end
        if (p.stall && s.prev_stall && (p.wv !== s.prev_wv || p.rv !== s.prev_rv)) s.held_err++;
        s.prev_stall = p.stall;
        s.prev_wv    = p.wv;
        s.prev_rv    = p.rv;
        return s;
    endfunction

    always @(negedge clk) begin
        samp_t sp [3];
        sp[0] = '{ia.busy, ia.done, ia.stall, ia.wr_wen, ia.rd_ren, ia.wr_ctrl_vars, ia.rd_ctrl_vars};
        sp[1] = '{ib.busy, ib.done, ib.stall, ib.wr_wen, ib.rd_ren, ib.wr_ctrl_vars, ib.rd_ctrl_vars};
        sp[2] = '{ic.busy, ic.done, ic.stall, ic.wr_wen, ic.rd_ren, ic.wr_ctrl_vars, ic.rd_ctrl_vars};
        for (int i = 0; i < 3; i++) begin
            if (seen[i] != ep[i]) begin
                seen[i] = ep[i];
                st[i]   = '0;
                st[i].k = -1;
            end
            st[i] = upd(st[i], sp[i], E0[i], E1[i], E2[i], RD[i]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done_a(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            tick(1);
            if (ia.done === 1'b1) got = 1'b1;
        end
        chk(tag, 64'(got), 64'd1);
        tick(2);
    endtask

    initial begin
        ia.start = 1'b0; ia.flush = 1'b0; ia.stall = 1'b0;
        ib.start = 1'b0; ib.flush = 1'b0; ib.stall = 1'b0;
        ic.start = 1'b0; ic.flush = 1'b0; ic.stall = 1'b0;

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_busy", 64'(ia.busy), 64'd0);
        chk("rst_done", 64'(ia.done), 64'd0);
        chk("rst_wen", 64'(ia.wr_wen), 64'd0);
        chk("rst_ren", 64'(ia.rd_ren), 64'd0);
        chk("rst_wv", 64'(ia.wr_ctrl_vars), 64'd0);
        chk("rst_rv", 64'(ia.rd_ctrl_vars), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("idle_busy", 64'(ia.busy), 64'd0);

        // Pass 1: all three instances start on the same edge; A also sees a start while busy.
        ep[0]++; ep[1]++; ep[2]++;
        ia.start = 1'b1; ib.start = 1'b1; ic.start = 1'b1;
        tick(1);
        ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
        chk("p1_wen_k1", 64'(ia.wr_wen), 64'd1);
        chk("p1_ren_k1", 64'(ia.rd_ren), 64'd0);
        chk("p1_busy_k1", 64'(ia.busy), 64'd1);
        tick(49);
        ia.start = 1'b1;
        tick(1);
        ia.start = 1'b0;
        wait_done_a("p1_done_seen");
        chk("p1_wen_first", 64'(st[0].wen_first), 64'd1);
        chk("p1_wen_last", 64'(st[0].wen_last), 64'd4096);
        chk("p1_wen_n", 64'(st[0].wen_n), 64'd4096);
        chk("p1_ren_first", 64'(st[0].ren_first), 64'd2);
        chk("p1_ren_last", 64'(st[0].ren_last), 64'd4097);
        chk("p1_ren_n", 64'(st[0].ren_n), 64'd4096);
        chk("p1_done_k", 64'(st[0].done_k), 64'd4098);
        chk("p1_done_n", 64'(st[0].done_n), 64'd1);
        chk("p1_busy_first", 64'(st[0].busy_first), 64'd1);
        chk("p1_busy_last", 64'(st[0].busy_last), 64'd4097);
        chk("p1_busy_n", 64'(st[0].busy_n), 64'd4097);
        chk("p1_wv_first", 64'(st[0].wv_first), 64'd0);
        chk("p1_wv_last", 64'(st[0].wv_last), {16'd0, 16'd63, 16'd63, 16'd0});
        chk("p1_order", 64'(st[0].ord_err), 64'd0);
        chk("p1_gate", 64'(st[0].gate_err), 64'd0);
        chk("p1_busy_after", 64'(ia.busy), 64'd0);

        chk("b_wen_n", 64'(st[1].wen_n), 64'd8);
        chk("b_wen_last", 64'(st[1].wen_last), 64'd8);
        chk("b_ren_first", 64'(st[1].ren_first), 64'd2);
        chk("b_ren_last", 64'(st[1].ren_last), 64'd9);
        chk("b_done_k", 64'(st[1].done_k), 64'd10);
        chk("b_order", 64'(st[1].ord_err), 64'd0);
        chk("b_gate", 64'(st[1].gate_err), 64'd0);

        chk("c_wen_last", 64'(st[2].wen_last), 64'd64);
        chk("c_ren_first", 64'(st[2].ren_first), 64'd65);
        chk("c_ren_last", 64'(st[2].ren_last), 64'd128);
        chk("c_drain_ren", 64'(st[2].drain_ren), 64'd64);
        chk("c_done_k", 64'(st[2].done_k), 64'd129);
        chk("c_done_n", 64'(st[2].done_n), 64'd1);
        chk("c_order", 64'(st[2].ord_err), 64'd0);
        chk("c_gate", 64'(st[2].gate_err), 64'd0);

        // Pass 2: stall cycles 10..14 of the pass.
        ep[0]++;
        ia.start = 1'b1;
        tick(1);
        ia.start = 1'b0;
        tick(9);
        ia.stall = 1'b1;
        tick(2);
        chk("p2_stall_wen", 64'(ia.wr_wen), 64'd0);
        chk("p2_stall_ren", 64'(ia.rd_ren), 64'd0);
        tick(3);
        ia.stall = 1'b0;
        wait_done_a("p2_done_seen");
        chk("p2_wen_last", 64'(st[0].wen_last), 64'd4101);
        chk("p2_ren_last", 64'(st[0].ren_last), 64'd4102);
        chk("p2_done_k", 64'(st[0].done_k), 64'd4103);
        chk("p2_wen_n", 64'(st[0].wen_n), 64'd4096);
        chk("p2_held", 64'(st[0].held_err), 64'd0);
        chk("p2_gate", 64'(st[0].gate_err), 64'd0);
        chk("p2_order", 64'(st[0].ord_err), 64'd0);

        // Pass 3: flush together with start at cycle 100, then a clean pass.
        ep[0]++;
        ia.start = 1'b1;
        tick(1);
        ia.start = 1'b0;
        tick(99);
        ia.flush = 1'b1;
        ia.start = 1'b1;
        tick(1);
        ia.flush = 1'b0;
        ia.start = 1'b0;
        chk("fl_busy", 64'(ia.busy), 64'd0);
        chk("fl_wen", 64'(ia.wr_wen), 64'd0);
        chk("fl_ren", 64'(ia.rd_ren), 64'd0);
        chk("fl_wv", 64'(ia.wr_ctrl_vars), 64'd0);
        chk("fl_rv", 64'(ia.rd_ctrl_vars), 64'd0);
        tick(1);
        chk("fl_start_ignored", 64'(ia.busy), 64'd0);
        chk("fl_no_done", 64'(st[0].done_n), 64'd0);
        ep[0]++;
        ia.start = 1'b1;
        tick(1);
        ia.start = 1'b0;
        wait_done_a("p3_done_seen");
        chk("p3_wen_n", 64'(st[0].wen_n), 64'd4096);
        chk("p3_done_k", 64'(st[0].done_k), 64'd4098);
        chk("p3_wv_first", 64'(st[0].wv_first), 64'd0);
        chk("p3_order", 64'(st[0].ord_err), 64'd0);
        chk("p3_gate", 64'(st[0].gate_err), 64'd0);

        // Pass 4: asynchronous reset in the middle of cycle 200.
        ep[0]++;
        ia.start = 1'b1;
        tick(1);
        ia.start = 1'b0;
        tick(199);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy", 64'(ia.busy), 64'd0);
        chk("ar_done", 64'(ia.done), 64'd0);
        chk("ar_wen", 64'(ia.wr_wen), 64'd0);
        chk("ar_ren", 64'(ia.rd_ren), 64'd0);
        chk("ar_wv", 64'(ia.wr_ctrl_vars), 64'd0);
        chk("ar_rv", 64'(ia.rd_ctrl_vars), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("ar_idle_busy", 64'(ia.busy), 64'd0);
        chk("ar_idle_wen", 64'(ia.wr_wen), 64'd0);
        chk("ar_no_done", 64'(st[0].done_n), 64'd0);
        chk("ar_wen_n", 64'(st[0].wen_n), 64'd199);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
